hash_engine_arbiter: RTL and testbench

Shares a single hash engine (Poseidon core) between NUM_REQ DMA ingress requesters.
- Picks one requester round-robin, latches its 512-bit block and issues it to the engine.
- Waits for the engine result under a watchdog and returns it, tagged with the requester ID.
- Sits between the DMA ingress channels and the hash engine; obeys the physical security interlock (breach → permanent lock until reset).

---
 rtl/hash_engine_arbiter_if.sv | 33 +++
 rtl/hash_engine_arbiter.sv | 175 +++++++++++++++++
 tb/tb_hash_engine_arbiter.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/hash_engine_arbiter_if.sv
// Bundles the requester, engine and response channels of hash_engine_arbiter.
// Valid/ready: a beat transfers on a clock edge where valid and ready are both 1; the sender holds valid and data stable until then.
interface hash_engine_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 512,
  parameter int RES_W   = 256
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      eng_start;
  logic [DATA_W-1:0]         eng_data;
  logic                      eng_abort;
  logic                      eng_done;
  logic [RES_W-1:0]          eng_result;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [ID_W-1:0]           rsp_id;
  logic [RES_W-1:0]          rsp_data;
  logic                      rsp_err;

  modport slave (
    input  req_valid, req_data, eng_done, eng_result, rsp_ready,
    output req_ready, eng_start, eng_data, eng_abort, rsp_valid, rsp_id, rsp_data, rsp_err
  );

  modport master (
    output req_valid, req_data, eng_done, eng_result, rsp_ready,
    input  req_ready, eng_start, eng_data, eng_abort, rsp_valid, rsp_id, rsp_data, rsp_err
  );
endinterface

// File: rtl/hash_engine_arbiter.sv
// Round-robin share of one hash engine between NUM_REQ requesters, with watchdog and breach lock.
// Define ARB_PRIO0_EN to give requester 0 absolute priority over the round-robin of the others.
module hash_engine_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_W         = 512,
  parameter int RES_W          = 256,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       security_breach,
  output logic [1:0] status_code,
  output logic [2:0] o_dbg_state,
  hash_engine_arbiter_if.slave bus
);
  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_RESP  = 3'd3,
    S_LOCK  = 3'd4
  } state_t;

  state_t            r_state;
  logic [ID_W-1:0]   r_ptr;
  logic [ID_W-1:0]   r_id;
  logic [TMR_W-1:0]  r_timer;
  logic [DATA_W-1:0] r_eng_data;
  logic              r_eng_start;
  logic              r_eng_abort;
  logic              r_rsp_valid;
  logic [RES_W-1:0]  r_rsp_data;
  logic              r_rsp_err;
  logic [1:0]        r_status;

  logic [ID_W-1:0]   w_gnt;
  logic              w_gnt_vld;
  logic              w_accept;
  logic [DATA_W-1:0] w_sel_data;

  // Grant search starts just after the last granted requester.
  always_comb begin
    int              idx;
    logic [ID_W-1:0] cand;
    idx       = 0;
    cand      = '0;
    w_gnt     = '0;
    w_gnt_vld = 1'b0;
`ifdef ARB_PRIO0_EN
    if (bus.req_valid[0]) begin
      w_gnt_vld = 1'b1;
    end else begin
      for (int j = 1; j < NUM_REQ; j++) begin
        idx  = 1 + ((int'(r_ptr) - 1 + j) % (NUM_REQ - 1));
        cand = ID_W'(idx);
        if (!w_gnt_vld && bus.req_valid[cand]) begin
          w_gnt_vld = 1'b1;
          w_gnt     = cand;
        end
      end
    end
`else
    for (int j = 1; j <= NUM_REQ; j++) begin
      idx  = (int'(r_ptr) + j) % NUM_REQ;
      cand = ID_W'(idx);
      if (!w_gnt_vld && bus.req_valid[cand]) begin
        w_gnt_vld = 1'b1;
        w_gnt     = cand;
      end
    end
`endif
  end

  always_comb begin
    w_sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gnt == ID_W'(i)) w_sel_data = bus.req_data[i*DATA_W +: DATA_W];
    end
  end

  assign w_accept = (r_state == S_IDLE) && !security_breach && w_gnt_vld;

  always_comb begin
    bus.req_ready = '0;
    if (w_accept) bus.req_ready[w_gnt] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_ptr       <= ID_W'(NUM_REQ - 1);
      r_id        <= '0;
      r_timer     <= '0;
      r_eng_data  <= '0;
      r_eng_start <= 1'b0;
      r_eng_abort <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
      r_status    <= 2'b00;
    end else begin
      r_eng_start <= 1'b0;
      r_eng_abort <= 1'b0;
      // A breach overrides everything and the lock survives its deassertion.
      if (security_breach || r_state == S_LOCK) begin
        r_state     <= S_LOCK;
        r_eng_data  <= '0;
        r_rsp_valid <= 1'b0;
        r_rsp_data  <= '0;
        r_rsp_err   <= 1'b0;
        r_status    <= 2'b11;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_accept) begin
              r_eng_data  <= w_sel_data;
              r_id        <= w_gnt;
`ifdef ARB_PRIO0_EN
              if (w_gnt != '0) r_ptr <= w_gnt;
`else
              r_ptr       <= w_gnt;
`endif
              r_eng_start <= 1'b1;
              r_status    <= 2'b01;
              r_state     <= S_ISSUE;
            end
          end
          S_ISSUE: begin
            r_timer <= '0;
            r_state <= S_WAIT;
          end
          S_WAIT: begin
            r_timer <= r_timer + 1'b1;
            // A done on the terminal cycle still counts as success.
            if (bus.eng_done) begin
              r_rsp_data  <= bus.eng_result;
              r_rsp_err   <= 1'b0;
              r_rsp_valid <= 1'b1;
              r_status    <= 2'b01;
              r_state     <= S_RESP;
            end else if (r_timer == TMR_W'(TIMEOUT_CYCLES - 1)) begin
              r_eng_abort <= 1'b1;
              r_rsp_data  <= '0;
              r_rsp_err   <= 1'b1;
              r_rsp_valid <= 1'b1;
              r_status    <= 2'b10;
              r_state     <= S_RESP;
            end
          end
          S_RESP: begin
            if (bus.rsp_ready) begin
              r_rsp_valid <= 1'b0;
              r_status    <= 2'b00;
              r_state     <= S_IDLE;
            end
          end
          default: r_state <= S_LOCK;
        endcase
      end
    end
  end

  assign bus.eng_start = r_eng_start;
  assign bus.eng_data  = r_eng_data;
  assign bus.eng_abort = r_eng_abort;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_id    = r_id;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.rsp_err   = r_rsp_err;
  assign status_code   = r_status;
  assign o_dbg_state   = r_state;
endmodule

// File: tb/tb_hash_engine_arbiter.sv
// Directed bench for hash_engine_arbiter: a transaction table plus backpressure, breach-lock and reset sequences.
module tb_hash_engine_arbiter;
  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 512;
  localparam int RES_W   = 256;
  localparam int TMO     = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       security_breach = 1'b0;
  logic [1:0] status_code;
  logic [2:0] dbg_state;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  hash_engine_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .RES_W(RES_W)) bus ();

  hash_engine_arbiter #(
    .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .RES_W(RES_W), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .security_breach(security_breach),
    .status_code(status_code),
    .o_dbg_state(dbg_state),
    .bus(bus)
  );

  typedef struct {
    logic [NUM_REQ-1:0] valid;
    int                 delay;
    bit                 tmo;
    logic [1:0]         exp_id;
    logic [RES_W-1:0]   result;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DATA_W-1:0] data_of(input int i);
    logic [7:0] b;
    b = 8'hA9 + 8'(i);
    return {64{b}};
  endfunction

  task automatic run_vec(input int k, input vec_t v);
    logic [NUM_REQ-1:0] onehot;
    int                 n;
    onehot = 4'b0001 << v.exp_id;
    n = v.tmo ? TMO : v.delay;
    bus.req_valid = v.valid;
    #1;
    chk($sformatf("v%0d req_ready", k), bus.req_ready, onehot);
    tick();
    chk($sformatf("v%0d eng_start", k), bus.eng_start, 1'b1);
    chk($sformatf("v%0d eng_data", k), bus.eng_data, data_of(v.exp_id));
    chk($sformatf("v%0d issue status", k), status_code, 2'b01);
    repeat (n) tick();
    if (!v.tmo) begin
      bus.eng_done   = 1'b1;
      bus.eng_result = v.result;
    end
    chk($sformatf("v%0d early rsp/abort", k), {bus.rsp_valid, bus.eng_abort}, 2'b00);
    tick();
    bus.eng_done   = 1'b0;
    bus.eng_result = '0;
    chk($sformatf("v%0d rsp_valid", k), bus.rsp_valid, 1'b1);
    chk($sformatf("v%0d rsp_id", k), bus.rsp_id, v.exp_id);
    chk($sformatf("v%0d rsp_data", k), bus.rsp_data, v.tmo ? '0 : v.result);
    chk($sformatf("v%0d rsp_err", k), bus.rsp_err, v.tmo);
    chk($sformatf("v%0d eng_abort", k), bus.eng_abort, v.tmo);
    chk($sformatf("v%0d resp status", k), status_code, v.tmo ? 2'b10 : 2'b01);
    tick();
    chk($sformatf("v%0d drained", k), {bus.rsp_valid, bus.eng_abort, status_code}, 4'b0000);
  endtask

  initial begin
    bus.req_valid  = '0;
    bus.eng_done   = 1'b0;
    bus.eng_result = '0;
    bus.rsp_ready  = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) bus.req_data[i*DATA_W +: DATA_W] = data_of(i);

    // Transaction table: valid mask, done delay after eng_start, timeout flag, expected id, result.
`ifdef ARB_PRIO0_EN
    vecs[0] = '{4'b1111, 2, 1'b0, 2'd0, 256'h1111};
    vecs[1] = '{4'b1111, 2, 1'b0, 2'd0, 256'h2222};
    vecs[2] = '{4'b1111, 2, 1'b0, 2'd0, 256'h3333};
    vecs[3] = '{4'b1111, 2, 1'b0, 2'd0, 256'h4444};
    vecs[4] = '{4'b1111, 2, 1'b0, 2'd0, 256'h5555};
`else
    vecs[0] = '{4'b1111, 2, 1'b0, 2'd0, 256'h1111};
    vecs[1] = '{4'b1111, 2, 1'b0, 2'd1, 256'h2222};
    vecs[2] = '{4'b1111, 2, 1'b0, 2'd2, 256'h3333};
    vecs[3] = '{4'b1111, 2, 1'b0, 2'd3, 256'h4444};
    vecs[4] = '{4'b1111, 2, 1'b0, 2'd0, 256'h5555};
`endif
    vecs[5]  = '{4'b0100, 5, 1'b0, 2'd2, 256'h1234};
    vecs[6]  = '{4'b0010, 0, 1'b1, 2'd1, 256'h0};
    vecs[7]  = '{4'b1000, TMO, 1'b0, 2'd3, 256'hBEEF};
    vecs[8]  = '{4'b1001, 3, 1'b0, 2'd0, {8{32'hDEAD0008}}};
    vecs[9]  = '{4'b0110, 2, 1'b0, 2'd1, 256'h9999};
    vecs[10] = '{4'b1110, 2, 1'b0, 2'd2, 256'hAAAA};
    vecs[11] = '{4'b1110, 1, 1'b0, 2'd3, 256'hBBBB};
    vecs[12] = '{4'b1110, 4, 1'b0, 2'd1, 256'hCCCC};

    repeat (2) tick();
    chk("reset status", status_code, 2'b00);
    chk("reset state", dbg_state, 3'd0);
    chk("reset outputs", {bus.eng_start, bus.eng_abort, bus.rsp_valid, bus.rsp_err, bus.rsp_id}, 6'd0);
    chk("reset eng_data", bus.eng_data, '0);
    chk("reset rsp_data", bus.rsp_data, '0);
    rst_n = 1'b1;
    tick();

    for (int k = 0; k < 13; k++) run_vec(k, vecs[k]);

    // Backpressure: response held for 10 cycles, stray eng_done ignored, no new accept.
    bus.req_valid = 4'b0010;
    #1;
    chk("bp req_ready", bus.req_ready, 4'b0010);
    tick();
    tick();
    tick();
    tick();
    bus.eng_done   = 1'b1;
    bus.eng_result = 256'hCAFE;
    bus.rsp_ready  = 1'b0;
    tick();
    bus.eng_done = 1'b0;
    for (int c = 0; c < 10; c++) begin
      chk($sformatf("bp hold c%0d", c), {bus.rsp_valid, bus.rsp_id, bus.req_ready, bus.rsp_data},
          {1'b1, 2'd1, 4'b0000, 256'hCAFE});
      if (c == 3) begin
        bus.eng_done   = 1'b1;
        bus.eng_result = 256'hBAD;
      end else begin
        bus.eng_done = 1'b0;
      end
      tick();
    end
    bus.eng_done  = 1'b0;
    bus.rsp_ready = 1'b1;
    tick();
    chk("bp drained", {bus.rsp_valid, status_code}, 3'b000);
    chk("bp accept after drain", bus.req_ready, 4'b0010);
    tick();
    chk("bp eng_start", bus.eng_start, 1'b1);
    chk("bp eng_data", bus.eng_data, data_of(1));

    // Breach pulse during WAIT locks until reset.
    tick();
    chk("wait state", dbg_state, 3'd2);
    security_breach = 1'b1;
    #1;
    chk("breach req_ready", bus.req_ready, 4'b0000);
    tick();
    security_breach = 1'b0;
    chk("lock status", status_code, 2'b11);
    chk("lock state", dbg_state, 3'd4);
    chk("lock rsp/start/abort", {bus.rsp_valid, bus.eng_start, bus.eng_abort}, 3'b000);
    chk("lock eng_data", bus.eng_data, '0);
    bus.req_valid  = 4'b1111;
    bus.eng_done   = 1'b1;
    bus.eng_result = 256'h7777;
    for (int c = 0; c < 20; c++) begin
      #1;
      chk($sformatf("lock hold c%0d", c), {status_code, bus.req_ready, bus.rsp_valid, bus.rsp_data},
          {2'b11, 4'b0000, 1'b0, 256'h0});
      tick();
    end
    bus.eng_done  = 1'b0;
    bus.req_valid = 4'b0000;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("post-reset status", status_code, 2'b00);
    chk("post-reset state", dbg_state, 3'd0);
    chk("post-reset eng_data", bus.eng_data, '0);
    bus.req_valid   = 4'b0001;
    security_breach = 1'b1;
    #1;
    chk("breach gates ready", bus.req_ready, 4'b0000);
    security_breach = 1'b0;
    #1;
    chk("post-reset req_ready", bus.req_ready, 4'b0001);
    tick();
    chk("post-reset eng_start", bus.eng_start, 1'b1);
    chk("post-reset eng_data", bus.eng_data, data_of(0));
    bus.req_valid = 4'b0000;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
